// File: rtl/n_bit_step_counter_pkg.sv
// Shared constants for the step counter and its bench.
// Mode encodings select wrap or saturate behaviour on carry/borrow.
package n_bit_step_counter_pkg;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;
endpackage

// File: rtl/full_adder.sv
// Full adder cell built from two half adders and an OR for the carry.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1;
   logic c1;
   logic c2;

   halfadder u_ha0 (.a(a),  .b(b),   .s(s1),  .c(c1));
   halfadder u_ha1 (.a(s1), .b(cin), .s(sum), .c(c2));
   orgate    u_or  (.a(c1), .b(c2),  .y(cout));
endmodule

// File: rtl/halfadder.sv
// Half adder primitive: sum and carry of two bits.
module halfadder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   xorgate u_x (.a(a), .b(b), .y(s));
   assign c = a & b;
endmodule

// File: rtl/orgate.sv
// Two-input OR gate primitive.
module orgate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

// File: rtl/ripple_addsub.sv
// WIDTH-bit ripple-carry adder/subtractor; sub=1 computes a + ~b + 1.
// For subtraction, cout=1 means no borrow occurred.
module ripple_addsub #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH-1:0] b_x;
   logic [WIDTH:0]   carry;

   assign carry[0] = sub;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      xorgate    u_inv (.a(b[i]), .b(sub), .y(b_x[i]));
      full_adder u_fa  (.a(a[i]), .b(b_x[i]), .cin(carry[i]),
                        .sum(sum[i]), .cout(carry[i+1]));
   end

   assign cout = carry[WIDTH];
endmodule

// File: rtl/xorgate.sv
// Two-input XOR gate primitive.
module xorgate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: rtl/n_bit_step_counter.sv
// Up/down counter with programmable step, load, and wrap or saturate on overflow.
// ovf pulses for one cycle per wrap or clamp event.
module n_bit_step_counter
   import n_bit_step_counter_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SAT_MODE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             at_max,
   output logic             at_zero
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             ovf_q;
   logic             ovf_d;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             range_evt;

   ripple_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (count_q),
      .b    (step),
      .sub  (~up),
      .sum  (sum),
      .cout (cout)
   );

   // Carry-out on increment, inverted carry-out (borrow) on decrement.
   assign range_evt = up ? cout : ~cout;

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = sum;
         ovf_d   = range_evt;
         if (SAT_MODE == MODE_SAT && range_evt) begin
            count_d = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count   = count_q;
   assign ovf     = ovf_q;
   assign at_max  = (count_q == {WIDTH{1'b1}});
   assign at_zero = (count_q == {WIDTH{1'b0}});
endmodule

// File: tb/tb_n_bit_step_counter.sv
// Bench for n_bit_step_counter: 16-bit wrap, 16-bit saturate and 4-bit wrap
// instances share stimulus and are compared against an arithmetic reference model.
module tb_n_bit_step_counter;
   import n_bit_step_counter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up;
   logic [15:0] step;
   logic        load;
   logic [15:0] load_val;

   logic [15:0] count_w;
   logic        ovf_w, at_max_w, at_zero_w;
   logic [15:0] count_s;
   logic        ovf_s, at_max_s, at_zero_s;
   logic [3:0]  count_n;
   logic        ovf_n, at_max_n, at_zero_n;
   logic [3:0]  step4;
   logic [3:0]  load_val4;

   assign step4     = step[3:0];
   assign load_val4 = load_val[3:0];

   int errors = 0;
   int checks = 0;

   // Reference model state, one slot per instance: 0=16 wrap, 1=16 sat, 2=4 wrap.
   longint mcnt [3];
   bit     movf [3];
   int     mwid [3] = '{16, 16, 4};
   bit     msat [3] = '{1'b0, 1'b1, 1'b0};

   n_bit_step_counter #(.WIDTH(16), .SAT_MODE(MODE_WRAP)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step), .load(load),
      .load_val(load_val), .count(count_w), .ovf(ovf_w), .at_max(at_max_w),
      .at_zero(at_zero_w));

   n_bit_step_counter #(.WIDTH(16), .SAT_MODE(MODE_SAT)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step), .load(load),
      .load_val(load_val), .count(count_s), .ovf(ovf_s), .at_max(at_max_s),
      .at_zero(at_zero_s));

   n_bit_step_counter #(.WIDTH(4), .SAT_MODE(MODE_WRAP)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step4), .load(load),
      .load_val(load_val4), .count(count_n), .ovf(ovf_n), .at_max(at_max_n),
      .at_zero(at_zero_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mcnt[k] = 0;
         movf[k] = 1'b0;
      end
   endtask

   // Plain integer arithmetic: compute the full result, then wrap or clamp.
   task automatic model_step();
      longint maxv;
      longint mask;
      longint r;
      for (int k = 0; k < 3; k++) begin
         maxv = (longint'(1) << mwid[k]) - 1;
         mask = maxv;
         movf[k] = 1'b0;
         if (load) begin
            mcnt[k] = longint'(load_val) & mask;
         end else if (en) begin
            if (up) r = mcnt[k] + (longint'(step) & mask);
            else    r = mcnt[k] - (longint'(step) & mask);
            if (r > maxv) begin
               movf[k] = 1'b1;
               r = msat[k] ? maxv : r - (maxv + 1);
            end else if (r < 0) begin
               movf[k] = 1'b1;
               r = msat[k] ? 0 : r + (maxv + 1);
            end
            mcnt[k] = r;
         end
      end
   endtask

   task automatic check_all(input string tag);
      longint maxv;
      for (int k = 0; k < 3; k++) begin
         maxv = (longint'(1) << mwid[k]) - 1;
         case (k)
            0: begin
               check({tag, ".w.count"}, count_w, mcnt[0]);
               check({tag, ".w.ovf"}, ovf_w, movf[0]);
               check({tag, ".w.at_max"}, at_max_w, mcnt[0] == maxv);
               check({tag, ".w.at_zero"}, at_zero_w, mcnt[0] == 0);
            end
            1: begin
               check({tag, ".s.count"}, count_s, mcnt[1]);
               check({tag, ".s.ovf"}, ovf_s, movf[1]);
               check({tag, ".s.at_max"}, at_max_s, mcnt[1] == maxv);
               check({tag, ".s.at_zero"}, at_zero_s, mcnt[1] == 0);
            end
            default: begin
               check({tag, ".n.count"}, count_n, mcnt[2]);
               check({tag, ".n.ovf"}, ovf_n, movf[2]);
               check({tag, ".n.at_max"}, at_max_n, mcnt[2] == maxv);
               check({tag, ".n.at_zero"}, at_zero_n, mcnt[2] == 0);
            end
         endcase
      end
   endtask

   // Inputs are stable across the edge; model advances with what the DUT sampled.
   task automatic cycle(input string tag);
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic l, input logic [15:0] lv, input logic e,
                        input logic u, input logic [15:0] s);
      load = l; load_val = lv; en = e; up = u; step = s;
   endtask

   int ovf_pulses;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
      model_reset();
      #2;
      check_all("reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      @(negedge clk);
      rst_n = 1'b1;

      // 4-bit wrap with step 7: 7, 14, 5 (ovf), 12, 3 (ovf).
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd7);
      for (int i = 0; i < 5; i++) cycle("step7");
      check("step7.n.final", count_n, 3);
      check("step7.n.ovf_final", ovf_n, 1);

      // Decrement through zero with borrow.
      drive(1'b1, 16'h0002, 1'b0, 1'b0, 16'd0);
      cycle("load2");
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'd5);
      cycle("down5a");
      check("down5a.w.const", count_w, 16'hFFFD);
      check("down5a.w.ovf_const", ovf_w, 1);
      check("down5a.s.clamp", count_s, 0);
      cycle("down5b");
      check("down5b.w.const", count_w, 16'hFFF8);
      check("down5b.w.ovf_const", ovf_w, 0);

      // Saturate at the top, ovf on every clamp.
      drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 16'd0);
      cycle("loadFFFE");
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd3);
      for (int i = 0; i < 3; i++) begin
         cycle("sat_up");
         check("sat_up.s.const", count_s, 16'hFFFF);
         check("sat_up.s.ovf_const", ovf_s, 1);
         check("sat_up.s.at_max_const", at_max_s, 1);
      end

      // Load beats enable in the same cycle.
      drive(1'b1, 16'h00FF, 1'b0, 1'b0, 16'd0);
      cycle("load00FF");
      drive(1'b1, 16'h1234, 1'b1, 1'b1, 16'hFFFF);
      cycle("load_vs_en");
      check("load_vs_en.w.const", count_w, 16'h1234);
      check("load_vs_en.w.ovf_const", ovf_w, 0);

      // Hold with en=0, and step=0 with en=1 in both directions.
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
      cycle("hold");
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0);
      cycle("step0_up");
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      cycle("step0_dn");
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
      cycle("load0");
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      cycle("step0_dn_at0");

      // Randomized mix of loads, holds and steps of varied size.
      for (int i = 0; i < 400; i++) begin
         load     = ($urandom_range(0, 7) == 0);
         load_val = 16'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         up       = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       step = 16'h0;
            1:       step = 16'($urandom_range(1, 15));
            2:       step = 16'($urandom_range(16'hF000, 16'hFFFF));
            default: step = 16'($urandom);
         endcase
         cycle("random");
      end

      // Asynchronous reset between edges, overriding load and en.
      drive(1'b1, 16'h0A5A, 1'b0, 1'b0, 16'h0);
      cycle("load0A5A");
      check("load0A5A.w.const", count_w, 16'h0A5A);
      drive(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'd1);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      check("async_rst.w.const", count_w, 0);
      cycle("rst_vs_load");
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd1);
      cycle("resume");
      check("resume.w.const", count_w, 1);

      // Full 16-bit sweep from zero: exactly one wrap pulse.
      drive(1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
      cycle("sweep_load0");
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'd1);
      ovf_pulses = 0;
      for (int i = 1; i <= 65536; i++) begin
         cycle("sweep");
         check("sweep.w.idx", count_w, i % 65536);
         if (ovf_w) ovf_pulses++;
      end
      check("sweep.w.ovf_pulses", ovf_pulses, 1);
      check("sweep.w.end_zero", at_zero_w, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
